// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single SDRAM controller port: video (p0) has fixed priority,
// CPU (p1) and aux (p2) share round-robin. Define ARB_STARVE_EN to bound p0 starvation of p1/p2.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 25,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p0_req,
  input  logic                    p0_wr,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_bytesel,
  output logic                    p0_ack,
  input  logic                    p1_req,
  input  logic                    p1_wr,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_bytesel,
  output logic                    p1_ack,
  input  logic                    p2_req,
  input  logic                    p2_wr,
  input  logic [ADDR_WIDTH-1:0]   p2_addr,
  input  logic [DATA_WIDTH-1:0]   p2_wdata,
  input  logic [DATA_WIDTH/8-1:0] p2_bytesel,
  output logic                    p2_ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_bytesel,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e                 state_q;
  logic [1:0]             grant_q;
  logic                   rr_last_q;  // 1: p2 was the last p1/p2 grant
  logic                   lo_req;
  logic                   pick_p0;
  logic                   any_req;
  logic                   force_lo;
  logic [1:0]             lo_sel;
  logic [1:0]             sel;
  logic                   sel_wr;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [BeWidth-1:0]     sel_bytesel;

`ifdef ARB_STARVE_EN
  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q;
  // Only force a lower grant when someone is there to take it, so p0 never deadlocks.
  assign force_lo = (starve_cnt_q == StarveLim) && lo_req;
`else
  assign force_lo = 1'b0;
`endif

  always_comb begin
    lo_req = p1_req | p2_req;
    if (p1_req && p2_req) begin
      lo_sel = rr_last_q ? 2'd1 : 2'd2;
    end else begin
      lo_sel = p1_req ? 2'd1 : 2'd2;
    end
    pick_p0 = p0_req && !force_lo;
    any_req = pick_p0 || lo_req;
    sel     = pick_p0 ? 2'd0 : lo_sel;
  end

  always_comb begin
    sel_wr      = p0_wr;
    sel_addr    = p0_addr;
    sel_wdata   = p0_wdata;
    sel_bytesel = p0_bytesel;
    case (sel)
      2'd1: begin
        sel_wr      = p1_wr;
        sel_addr    = p1_addr;
        sel_wdata   = p1_wdata;
        sel_bytesel = p1_bytesel;
      end
      2'd2: begin
        sel_wr      = p2_wr;
        sel_addr    = p2_addr;
        sel_wdata   = p2_wdata;
        sel_bytesel = p2_bytesel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 2'd0;
      rr_last_q    <= 1'b1;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_bytesel  <= '0;
      rdata        <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p2_ack       <= 1'b0;
`ifdef ARB_STARVE_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            mem_req     <= 1'b1;
            mem_wr      <= sel_wr;
            mem_addr    <= sel_addr;
            mem_wdata   <= sel_wdata;
            mem_bytesel <= sel_bytesel;
            grant_q     <= sel;
            state_q     <= StBusy;
            if (sel != 2'd0) rr_last_q <= (sel == 2'd2);
`ifdef ARB_STARVE_EN
            if (sel == 2'd0 && lo_req) starve_cnt_q <= starve_cnt_q + 4'd1;
            else                       starve_cnt_q <= '0;
`endif
          end
        end
        StBusy: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata   <= mem_rdata;
            p0_ack  <= (grant_q == 2'd0);
            p1_ack  <= (grant_q == 2'd1);
            p2_ack  <= (grant_q == 2'd2);
            state_q <= StAck;
          end
        end
        StAck: begin
          // Guard cycle lets the requester drop its level before the next sample.
          p0_ack  <= 1'b0;
          p1_ack  <= 1'b0;
          p2_ack  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: a controller model acks requests and a
// scoreboard of expected (port, rdata) pairs is checked on every pN_ack.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          p0_req, p1_req, p2_req;
  logic          p0_wr, p1_wr, p2_wr;
  logic [AW-1:0] p0_addr, p1_addr, p2_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p2_wdata;
  logic [BW-1:0] p0_bytesel, p1_bytesel, p2_bytesel;
  logic          p0_ack, p1_ack, p2_ack;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_bytesel;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int   checks;
  int   failures;
  exp_t exp_q[$];
  int   renew[3];
  int   ack_cnt[3];
  int   ack_delay;
  bit   ctrl_hold;

  sdram_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .p0_req     (p0_req),
    .p0_wr      (p0_wr),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_bytesel (p0_bytesel),
    .p0_ack     (p0_ack),
    .p1_req     (p1_req),
    .p1_wr      (p1_wr),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_bytesel (p1_bytesel),
    .p1_ack     (p1_ack),
    .p2_req     (p2_req),
    .p2_wr      (p2_wr),
    .p2_addr    (p2_addr),
    .p2_wdata   (p2_wdata),
    .p2_bytesel (p2_bytesel),
    .p2_ack     (p2_ack),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_bytesel(mem_bytesel),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
    if (a == 25'h100) return 32'hDEADBEEF;
    return {7'h0, a} ^ 32'hC0DE_0000;
  endfunction

  task automatic push_exp(input int port, input logic [AW-1:0] a);
    exp_q.push_back({2'(port), model_rdata(a)});
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Controller model: acks ack_delay cycles after mem_req rises.
  initial begin : ctrl
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !ctrl_hold) begin
        if (cnt >= ack_delay - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = model_rdata(mem_addr);
          cnt       = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: every ack must match the head of exp_q; requesters drop or renew on ack.
  initial begin : monitor
    logic [2:0] acks;
    int         port;
    exp_t       e;
    forever begin
      @(negedge clk);
      acks = {p2_ack, p1_ack, p0_ack};
      if (acks != 3'b000) begin
        port = acks[0] ? 0 : (acks[1] ? 1 : 2);
        checks++;
        if (!$onehot(acks)) begin
          failures++;
          $display("FAIL ack_onehot got=%b required=onehot", acks);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack got port=%0d required=no ack", port);
        end else begin
          e = exp_q.pop_front();
          if (port !== int'(e.port) || rdata !== e.rdata) begin
            failures++;
            $display("FAIL scoreboard got port=%0d rdata=%h required port=%0d rdata=%h",
                     port, rdata, e.port, e.rdata);
          end
        end
        ack_cnt[port]++;
        if (renew[port] > 0) begin
          renew[port]--;
        end else begin
          case (port)
            0:       p0_req = 1'b0;
            1:       p1_req = 1'b0;
            default: p2_req = 1'b0;
          endcase
        end
      end
    end
  end

  task automatic do_reset();
    reset  = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    p2_req = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      renew[i]   = 0;
      ack_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_wr, mem_addr, mem_wdata, mem_bytesel} !== '0) begin
      failures++;
      $display("FAIL reset_mem got=%h required=0",
               {mem_req, mem_wr, mem_addr, mem_wdata, mem_bytesel});
    end
    checks++;
    if ({p0_ack, p1_ack, p2_ack, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_ack_rdata got=%h required=0", {p0_ack, p1_ack, p2_ack, rdata});
    end
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got=%b required=0", mem_req);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    ack_delay  = 4;
    p1_addr    = 25'h000100;
    p1_wr      = 1'b0;
    p1_bytesel = 4'hF;
    push_exp(1, 25'h000100);
    p1_req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h000100 || mem_wr !== 1'b0) begin
      failures++;
      $display("FAIL single_grant got req=%b addr=%h wr=%b required req=1 addr=000100 wr=0",
               mem_req, mem_addr, mem_wr);
    end
    wait_drain(30);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_drain got left=%0d required=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_rdata_hold got=%h required=deadbeef", rdata);
    end
    checks++;
    if (ack_cnt[0] != 0 || ack_cnt[1] != 1 || ack_cnt[2] != 0) begin
      failures++;
      $display("FAIL single_ack_counts got=%0d/%0d/%0d required=0/1/0",
               ack_cnt[0], ack_cnt[1], ack_cnt[2]);
    end
  endtask

  task automatic test_priority();
    bit prev_req;
    bit seen;
    int low_run;
    do_reset();
    ack_delay = 1;
    p0_addr = 25'h10;
    p1_addr = 25'h20;
    p2_addr = 25'h30;
    p0_wr = 1'b0;
    p1_wr = 1'b0;
    p2_wr = 1'b0;
    push_exp(0, 25'h10);
    push_exp(1, 25'h20);
    push_exp(2, 25'h30);
    p0_req = 1'b1;
    p1_req = 1'b1;
    p2_req = 1'b1;
    prev_req = 1'b0;
    seen     = 1'b0;
    low_run  = 0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
      if (mem_req && !prev_req) begin
        if (seen) begin
          checks++;
          if (low_run < 2) begin
            failures++;
            $display("FAIL priority_gap got=%0d required>=2", low_run);
          end
        end
        seen = 1'b1;
      end
      low_run  = mem_req ? 0 : low_run + 1;
      prev_req = mem_req;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL priority_drain got left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ack_delay = 2;
    p1_addr = 25'h0AA0;
    p2_addr = 25'h0BB0;
    renew[1] = 2;
    renew[2] = 2;
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 25'h0AA0);
      push_exp(2, 25'h0BB0);
    end
    p1_req = 1'b1;
    p2_req = 1'b1;
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rr_drain got left=%0d required=0", exp_q.size());
    end
    checks++;
    if (ack_cnt[1] != 3 || ack_cnt[2] != 3) begin
      failures++;
      $display("FAIL rr_counts got=%0d/%0d required=3/3", ack_cnt[1], ack_cnt[2]);
    end
  endtask

  task automatic test_latched_stability();
    do_reset();
    ack_delay  = 6;
    p2_wr      = 1'b1;
    p2_addr    = 25'h1FFFFFC;
    p2_wdata   = 32'h12345678;
    p2_bytesel = 4'b0011;
    push_exp(2, 25'h1FFFFFC);
    p2_req = 1'b1;
    @(posedge clk);
    #1;
    p2_addr    = 25'h0;
    p2_wdata   = 32'hFFFF_0000;
    p2_bytesel = 4'b1100;
    p2_wr      = 1'b0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      checks++;
      if (mem_wr !== 1'b1 || mem_addr !== 25'h1FFFFFC || mem_wdata !== 32'h12345678 ||
          mem_bytesel !== 4'b0011) begin
        failures++;
        $display("FAIL latched_fields got wr=%b addr=%h wdata=%h be=%b required 1/1fffffc/12345678/0011",
                 mem_wr, mem_addr, mem_wdata, mem_bytesel);
      end
      @(negedge clk);
      #1;
    end
    wait_drain(30);
    checks++;
    if (exp_q.size() != 0 || ack_cnt[2] != 1) begin
      failures++;
      $display("FAIL latched_drain got left=%0d acks=%0d required 0/1", exp_q.size(), ack_cnt[2]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_delay = 2;
    ctrl_hold = 1'b0;
    p1_addr = 25'h40;
    p2_addr = 25'h80;
    p1_wr = 1'b0;
    p2_wr = 1'b0;
    push_exp(1, 25'h40);
    p1_req = 1'b1;
    wait_drain(30);
    // p1 was served last, so a tie now goes to p2; hold it in BUSY.
    ctrl_hold = 1'b1;
    p1_req = 1'b1;
    p2_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h80) begin
      failures++;
      $display("FAIL rr_tie_p2 got req=%b addr=%h required req=1 addr=80", mem_req, mem_addr);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_wr, mem_addr, mem_wdata, mem_bytesel, p0_ack, p1_ack, p2_ack, rdata} !== '0)
    begin
      failures++;
      $display("FAIL async_reset got req=%b addr=%h rdata=%h required all 0",
               mem_req, mem_addr, rdata);
    end
    repeat (2) @(posedge clk);
    #2;
    reset     = 1'b0;
    ctrl_hold = 1'b0;
    push_exp(1, 25'h40);
    push_exp(2, 25'h80);
    wait_drain(40);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_drain got left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_starve();
    do_reset();
    ack_delay = 1;
    p0_addr = 25'h1000;
    p1_addr = 25'h2000;
    p0_wr = 1'b0;
    p1_wr = 1'b0;
    renew[0] = 9;
    renew[1] = 1;
`ifdef ARB_STARVE_EN
    for (int i = 0; i < 8; i++) push_exp(0, 25'h1000);
    push_exp(1, 25'h2000);
    push_exp(0, 25'h1000);
    push_exp(0, 25'h1000);
    push_exp(1, 25'h2000);
`else
    for (int i = 0; i < 10; i++) push_exp(0, 25'h1000);
    push_exp(1, 25'h2000);
    push_exp(1, 25'h2000);
`endif
    p0_req = 1'b1;
    p1_req = 1'b1;
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL starve_drain got left=%0d required=0", exp_q.size());
    end
    checks++;
    if (ack_cnt[0] != 10 || ack_cnt[1] != 2) begin
      failures++;
      $display("FAIL starve_counts got=%0d/%0d required=10/2", ack_cnt[0], ack_cnt[1]);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    ack_delay  = 4;
    ctrl_hold  = 1'b0;
    reset      = 1'b1;
    p0_req     = 1'b0;
    p1_req     = 1'b0;
    p2_req     = 1'b0;
    p0_wr      = 1'b0;
    p1_wr      = 1'b0;
    p2_wr      = 1'b0;
    p0_addr    = '0;
    p1_addr    = '0;
    p2_addr    = '0;
    p0_wdata   = 32'hA0A0_0000;
    p1_wdata   = 32'hA1A1_0000;
    p2_wdata   = 32'hA2A2_0000;
    p0_bytesel = 4'hF;
    p1_bytesel = 4'hF;
    p2_bytesel = 4'hF;
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_latched_stability();
    test_reset_mid();
    test_starve();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
